// File: rtl/phoenix_ni_tx.sv
// Network-interface transmitter: serialises a packet descriptor plus local
// payload into header, size and payload flits under router credit flow control.
module phoenix_ni_tx #(
  parameter int unsigned TAM_FLIT = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pkt_valid,
  input  logic [TAM_FLIT-1:0] pkt_target,
  input  logic [TAM_FLIT-1:0] pkt_size,
  output logic                pkt_ready,
  input  logic                pl_valid,
  input  logic [TAM_FLIT-1:0] pl_data,
  output logic                pl_ready,
  output logic                tx,
  output logic [TAM_FLIT-1:0] data_out,
  input  logic                credit_i,
  output logic                busy,
  output logic                err_size,
  output logic [CNT_W-1:0]    pkt_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  state_t                state_q;
  logic [TAM_FLIT-1:0]   target_q;
  logic [TAM_FLIT-1:0]   size_q;
  logic [TAM_FLIT-1:0]   rem_q;
  logic                  err_size_q;
  logic [CNT_W-1:0]      pkt_count_q;

  // Link-side flit selection; a reset cycle never launches a flit.
  always_comb begin
    tx       = 1'b0;
    pl_ready = 1'b0;
    data_out = '0;
    case (state_q)
      HEADER: begin
        tx       = credit_i & reset;
        data_out = target_q;
      end
      SIZE: begin
        tx       = credit_i & reset;
        data_out = size_q;
      end
      PAYLOAD: begin
        tx       = credit_i & pl_valid & reset;
        pl_ready = credit_i & reset;
        data_out = pl_data;
      end
      default: begin
        tx       = 1'b0;
        pl_ready = 1'b0;
        data_out = '0;
      end
    endcase
  end

  assign pkt_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign err_size  = err_size_q;
  assign pkt_count = pkt_count_q;

  // Packet sequencer: advances only on an actual flit transfer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      target_q    <= '0;
      size_q      <= '0;
      rem_q       <= '0;
      err_size_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      err_size_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pkt_valid) begin
            if (pkt_size != '0) begin
              target_q <= pkt_target;
              size_q   <= pkt_size;
              rem_q    <= pkt_size;
              state_q  <= HEADER;
            end else begin
              err_size_q <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (credit_i) state_q <= SIZE;
        end
        SIZE: begin
          if (credit_i) state_q <= PAYLOAD;
        end
        PAYLOAD: begin
          if (credit_i && pl_valid) begin
            rem_q <= rem_q - TAM_FLIT'(1);
            if (rem_q == TAM_FLIT'(1)) begin
              state_q     <= IDLE;
              pkt_count_q <= pkt_count_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
